// File: rtl/interval_hist.sv
// Per-bin hit histogram over fixed-length frames of one-hot samples.
// Each frame's counts drain as a valid/ready record stream, then clear.
module interval_hist #(
  parameter int NUM       = 8,
  parameter int CNT_WIDTH = 16,
  parameter int FRAME_LEN = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [NUM-1:0]          interval_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [$clog2(NUM)-1:0]  out_bin_o,
  output logic [CNT_WIDTH-1:0]    out_count_o,
  output logic                    out_last_o,
  output logic                    error_o
);

  localparam int IW = $clog2(NUM);

  typedef enum logic {ACCUM, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] counts_q [NUM];
  logic [31:0]          smp_q;
  logic [IW-1:0]        idx_q;
  logic                 err_q;

  logic          onehot;
  logic [IW-1:0] hit;
  logic          accept;
  logic          last_smp;
  logic          hs;
  logic          drain_end;

  always_comb begin
    onehot = (interval_i != '0) &&
             ((interval_i & (interval_i - NUM'(1))) == '0);
    hit = '0;
    for (int i = 0; i < NUM; i++) begin
      if (interval_i[i]) hit = IW'(i);
    end
  end

  assign in_ready_o  = (state_q == ACCUM) && !clear_i && !rst_i;
  assign out_valid_o = (state_q == DRAIN) && !clear_i;
  assign out_bin_o   = idx_q;
  assign out_count_o = (state_q == DRAIN) ? counts_q[idx_q] : '0;
  assign out_last_o  = (state_q == DRAIN) && (idx_q == IW'(NUM-1));
  assign error_o     = err_q;

  assign accept    = in_valid_i && in_ready_o;
  assign last_smp  = (smp_q == 32'(FRAME_LEN-1));
  assign hs        = out_valid_o && out_ready_i;
  assign drain_end = hs && (idx_q == IW'(NUM-1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM: if (accept && last_smp) state_d = DRAIN;
      DRAIN: if (drain_end) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
    if (clear_i) state_d = ACCUM;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ACCUM;
    else       state_q <= state_d;
  end

  // Counters saturate instead of wrapping on long frames.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM; i++) counts_q[i] <= '0;
    end else if (clear_i || drain_end) begin
      for (int i = 0; i < NUM; i++) counts_q[i] <= '0;
    end else if (accept && onehot && (counts_q[hit] != '1)) begin
      counts_q[hit] <= counts_q[hit] + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      smp_q <= '0;
      idx_q <= '0;
      err_q <= 1'b0;
    end else if (clear_i) begin
      smp_q <= '0;
      idx_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept) begin
        smp_q <= last_smp ? '0 : smp_q + 32'd1;
        if (!onehot) err_q <= 1'b1;
        if (last_smp) idx_q <= '0;
      end
      if (drain_end)  idx_q <= '0;
      else if (hs)    idx_q <= idx_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_interval_hist.sv
// Directed bench for interval_hist with a per-cycle reference model.
// Small CNT_WIDTH and FRAME_LEN exercise saturation and frame ends.
module tb_interval_hist;

  localparam int NUM   = 8;
  localparam int CW    = 4;
  localparam int FRAME = 20;
  localparam int MAXC  = (1 << CW) - 1;

  logic          clk = 0;
  logic          rst = 1;
  logic          clr = 0;
  logic          ivalid = 0;
  logic          irdy;
  logic [7:0]    intv = '0;
  logic          ovalid;
  logic          ordy = 1;
  logic [2:0]    obin;
  logic [CW-1:0] ocnt;
  logic          olast;
  logic          err;

  interval_hist #(
    .NUM(NUM), .CNT_WIDTH(CW), .FRAME_LEN(FRAME)
  ) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clr),
    .in_valid_i(ivalid), .in_ready_o(irdy),
    .interval_i(intv), .out_valid_o(ovalid),
    .out_ready_i(ordy), .out_bin_o(obin),
    .out_count_o(ocnt), .out_last_o(olast),
    .error_o(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: frame-level histogram semantics
  int m_cnt [NUM];
  int m_n;
  bit m_drain;
  int m_idx;
  bit m_err;

  always @(posedge clk or posedge rst) begin
    if (rst || clr) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_n = 0; m_drain = 0; m_idx = 0; m_err = 0;
    end else if (m_drain) begin
      if (ordy) begin
        if (m_idx == NUM-1) begin
          foreach (m_cnt[i]) m_cnt[i] = 0;
          m_drain = 0;
          m_idx = 0;
        end else m_idx++;
      end
    end else if (ivalid) begin
      if ($countones(intv) == 1) begin
        for (int i = 0; i < NUM; i++)
          if (intv[i] && m_cnt[i] < MAXC) m_cnt[i]++;
      end else m_err = 1;
      m_n++;
      if (m_n == FRAME) begin
        m_n = 0; m_drain = 1; m_idx = 0;
      end
    end
  end

  typedef struct packed {
    logic [2:0]    bin;
    logic [CW-1:0] cnt;
    logic          last;
  } rec_t;

  rec_t got [$];
  rec_t prev;
  bit   pv, pr, pc;
  int   vcyc, ircyc;

  always @(negedge clk) begin
    chk("in_ready", 32'(irdy), 32'(!rst && !clr && !m_drain));
    chk("out_valid", 32'(ovalid), 32'(m_drain && !clr));
    chk("error", 32'(err), 32'(m_err));
    if (m_drain && !clr) begin
      chk("rec_bin", 32'(obin), 32'(m_idx));
      chk("rec_cnt", 32'(ocnt), 32'(m_cnt[m_idx]));
      chk("rec_last", 32'(olast), 32'(m_idx == NUM-1));
    end
    if (pv && !pr && !pc && !rst) begin
      chk("stall_valid", 32'(ovalid), 32'd1);
      chk("stall_rec", 32'({obin, ocnt, olast}), 32'(prev));
    end
    if (ovalid) vcyc++;
    if (!irdy && !rst) ircyc++;
    if (ovalid && ordy && !clr)
      got.push_back(rec_t'({obin, ocnt, olast}));
    pv = ovalid; pr = ordy; pc = clr;
    prev = rec_t'({obin, ocnt, olast});
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] v);
    bit acc = 0;
    int n = 0;
    ivalid = 1; intv = v;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = irdy;
      step();
      n++;
    end
    ivalid = 0;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic frame_mod(input int m);
    for (int i = 0; i < FRAME; i++) send(8'(1 << (i % m)));
  endtask

  task automatic wait_recs(input int n);
    int c = 0;
    while (got.size() < n && c < 200) begin
      step(); c++;
    end
    if (got.size() < n) chk("drain_timeout", 0, 1);
  endtask

  task automatic check_frame(input int e [NUM]);
    chk("nrecs", got.size(), NUM);
    for (int i = 0; i < NUM && i < got.size(); i++) begin
      chk("lit_bin", 32'(got[i].bin), 32'(i));
      chk("lit_cnt", 32'(got[i].cnt), 32'(e[i]));
      chk("lit_last", 32'(got[i].last), 32'(i == NUM-1));
    end
  endtask

  initial begin
    int e32 [NUM] = '{3, 3, 3, 3, 2, 2, 2, 2};
    int esat [NUM] = '{0, 0, 15, 0, 0, 0, 0, 0};
    int eerr [NUM] = '{6, 12, 0, 0, 0, 0, 0, 0};
    int c;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(irdy), 0);
    chk("rst_out_valid", 32'(ovalid), 0);
    chk("rst_bin", 32'(obin), 0);
    chk("rst_cnt", 32'(ocnt), 0);
    chk("rst_last", 32'(olast), 0);
    chk("rst_err", 32'(err), 0);
    rst = 0;
    step();
    vcyc = 0; ircyc = 0;

    // bins cycling 0..7 over one frame
    got.delete();
    frame_mod(8);
    wait_recs(NUM);
    check_frame(e32);
    chk("valid_cycles", vcyc, NUM);
    chk("dead_cycles", ircyc, NUM);

    // saturation on bin 2
    got.delete();
    for (int i = 0; i < FRAME; i++) send(8'h04);
    wait_recs(NUM);
    check_frame(esat);

    // non-one-hot samples raise the sticky error
    got.delete();
    chk("err_before", 32'(err), 0);
    send(8'h00);
    chk("err_after_zero", 32'(err), 1);
    send(8'h30);
    for (int i = 0; i < 6; i++) send(8'h01);
    for (int i = 0; i < 12; i++) send(8'h02);
    wait_recs(NUM);
    check_frame(eerr);
    chk("err_kept", 32'(err), 1);
    clr = 1; step(); clr = 0;
    chk("err_cleared", 32'(err), 0);

    // random stalls with upstream pushing during drain
    got.delete();
    frame_mod(8);
    ivalid = 1; intv = 8'h01;
    c = 0;
    while (got.size() < NUM && c < 300) begin
      ordy = 1'($urandom_range(0, 1));
      step(); c++;
    end
    ivalid = 0; ordy = 1;
    check_frame(e32);

    // clear aborts drain at record 3
    got.delete();
    frame_mod(4);
    wait_recs(3);
    chk("abort_bin", 32'(obin), 3);
    clr = 1; step(); clr = 0;
    chk("abort_valid", 32'(ovalid), 0);
    chk("abort_err", 32'(err), 0);
    got.delete();
    frame_mod(8);
    wait_recs(NUM);
    check_frame(e32);

    // asynchronous reset mid-frame
    got.delete();
    send(8'h00);
    for (int i = 0; i < 5; i++) send(8'h02);
    rst = 1;
    #2;
    chk("arst_in_ready", 32'(irdy), 0);
    chk("arst_err", 32'(err), 0);
    chk("arst_valid", 32'(ovalid), 0);
    chk("arst_cnt", 32'(ocnt), 0);
    step();
    rst = 0;
    step();
    got.delete();
    frame_mod(8);
    wait_recs(NUM);
    check_frame(e32);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
